// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU memory responder.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 32;

  // Data-side transaction FSM states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Latched data operation; OP_BAD marks read and write requested together.
  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_BAD
  } op_t;

  function automatic op_t decode_op(input logic rd, input logic wr);
    if (rd && wr) return OP_BAD;
    else if (wr)  return OP_WR;
    else          return OP_RD;
  endfunction

  // True when a word address lies beyond a 2**depth_log2-word RAM.
  function automatic logic addr_oob(input logic [ADDR_W-1:0] a,
                                    input int unsigned depth_log2);
    logic [ADDR_W-1:0] hi;
    hi = a >> depth_log2;
    return (hi != '0);
  endfunction

endpackage

// File: rtl/mem_dp_ram.sv
// Synchronous dual-port RAM: port A read-only (fetch), port B read/write (data).
// Both ports are read-before-write; structured for block RAM inference.
module mem_dp_ram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] addr_a,
  output logic [DATA_W-1:0]     q_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [DEPTH_LOG2-1:0] addr_b,
  input  logic [DATA_W-1:0]     wdata_b,
  output logic [DATA_W-1:0]     q_b
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Port A: registered fetch read, output register cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) q_a <= '0;
    else      q_a <= mem[addr_a];
  end

  // Port B: registered read on enable, write commits after the old word is read.
  always_ff @(posedge clk) begin
    if (en_b) q_b <= mem[addr_b];
    if (we_b) mem[addr_b] <= wdata_b;
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU memory responder: fetch port plus a wait-state data port on one RAM.
// Optional macro MEM_BOUNDS_CHECK_EN: out-of-range data addresses complete
// with mem_err instead of wrapping.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] fetch_instr,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   laddr;
  logic [DATA_W-1:0]   ldata;
  op_t                 lop;
  logic                loob;

  logic                req;
  op_t                 op_in;
  logic                oob_in;
  logic                enter_resp;
  logic [DEPTH_LOG2-1:0] b_addr;
  op_t                 b_op;
  logic                b_oob;
  logic                en_b;
  logic                we_b;
  logic [DATA_W-1:0]   q_b;

  assign req   = read_enable | write_enable;
  assign op_in = decode_op(read_enable, write_enable);

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_in = addr_oob(addr_mem, DEPTH_LOG2);
`else
  assign oob_in = 1'b0;
`endif

  // Address bits above the RAM depth only matter to the bounds check.
  logic unused_hi;
  assign unused_hi = &{1'b0, addr, addr_mem, laddr};

  // The RAM read is launched on the edge that enters RESP so its output is
  // ready to be captured into mem_rdata on the RESP edge. With zero wait
  // states that edge is the sampling edge, so the live inputs are used.
  assign enter_resp = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && (cnt == '0));

  // Port B address/op source and RAM strobes.
  always_comb begin
    b_addr = laddr[DEPTH_LOG2-1:0];
    b_op   = lop;
    b_oob  = loob;
    if (state == IDLE) begin
      b_addr = addr_mem[DEPTH_LOG2-1:0];
      b_op   = op_in;
      b_oob  = oob_in;
    end
    en_b = rst && enter_resp && (b_op == OP_RD) && !b_oob;
    we_b = rst && (state == RESP) && (lop == OP_WR) && !loob;
  end

  mem_dp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .addr_a (addr[DEPTH_LOG2-1:0]),
    .q_a    (fetch_instr),
    .en_b   (en_b),
    .we_b   (we_b),
    .addr_b (b_addr),
    .wdata_b(ldata),
    .q_b    (q_b)
  );

  // Data FSM: latch request, count wait states, respond for one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      laddr     <= '0;
      ldata     <= '0;
      lop       <= OP_RD;
      loob      <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            laddr <= addr_mem;
            ldata <= data_out;
            lop   <= op_in;
            loob  <= oob_in;
            cnt   <= CNT_INIT;
            state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          mem_ready <= 1'b1;
          mem_err   <= (lop == OP_BAD) || loob;
          if ((lop == OP_BAD) || ((lop == OP_RD) && loob)) mem_rdata <= '0;
          else if (lop == OP_RD)                           mem_rdata <= q_b;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder with three wait-state settings
// (0, 1, 3) sharing one stimulus bus.
module tb_cpu_mem_responder;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] addr = '0;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [14:0] addr_mem = '0;
  logic [31:0] data_out = '0;

  logic [31:0] fi    [3];
  logic [31:0] rdata [3];
  logic [2:0]  rdy;
  logic [2:0]  err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .addr(addr), .fetch_instr(fi[0]),
    .read_enable(read_enable), .write_enable(write_enable),
    .addr_mem(addr_mem), .data_out(data_out),
    .mem_rdata(rdata[0]), .mem_ready(rdy[0]), .mem_err(err[0]));

  cpu_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .rst(rst), .addr(addr), .fetch_instr(fi[1]),
    .read_enable(read_enable), .write_enable(write_enable),
    .addr_mem(addr_mem), .data_out(data_out),
    .mem_rdata(rdata[1]), .mem_ready(rdy[1]), .mem_err(err[1]));

  cpu_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst(rst), .addr(addr), .fetch_instr(fi[2]),
    .read_enable(read_enable), .write_enable(write_enable),
    .addr_mem(addr_mem), .data_out(data_out),
    .mem_rdata(rdata[2]), .mem_ready(rdy[2]), .mem_err(err[2]));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [14:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One-cycle request pulse; returns at the negedge right after the sampling edge.
  task automatic issue(input logic rd, input logic wr, input logic [14:0] a, input logic [31:0] d);
    @(negedge clk);
    read_enable  = rd;
    write_enable = wr;
    addr_mem     = a;
    data_out     = d;
    @(negedge clk);
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  // Bounded wait for mem_ready; latency counted in cycles after the sampling edge.
  task automatic await_ready(input int idx, input int lat, input string tag);
    int got;
    got = -1;
    for (int k = 0; k < 20; k++) begin
      if (rdy[idx]) begin
        got = k;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(got), 32'(lat));
  endtask

  task automatic txn(input int idx, input int lat, input logic rd, input logic wr,
                     input logic [14:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee, input string tag);
    issue(rd, wr, a, d);
    await_ready(idx, lat, tag);
    chk({tag, "_rdata"}, rdata[idx], er);
    chk({tag, "_err"}, 32'(err[idx]), 32'(ee));
    @(negedge clk);
    chk({tag, "_pulse_width"}, 32'(rdy[idx]), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int pulses;

    vecs[0] = '{1'b0, 1'b1, 15'h005, 32'hDEADBEEF, 32'hA5A50000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 15'h005, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 15'h003, 32'h12345678, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 15'h003, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 15'h003, 32'h0,        32'h12345678, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 15'h405, 32'h0BAD0BAD, 32'h12345678, BC};
    vecs[6] = '{1'b1, 1'b0, 15'h005, 32'h0,        BC ? 32'hDEADBEEF : 32'h0BAD0BAD, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 15'h405, 32'h0,        BC ? 32'h00000000 : 32'h0BAD0BAD, BC};
    vecs[8] = '{1'b0, 1'b1, 15'h400, 32'h55AA55AA, BC ? 32'h00000000 : 32'h0BAD0BAD, BC};
    vecs[9] = '{1'b1, 1'b0, 15'h000, 32'h0,        BC ? 32'hA5A50000 : 32'h55AA55AA, 1'b0};

    // Power-on reset, two edges.
    repeat (2) @(negedge clk);
    chk("por_ready", {29'd0, rdy}, 32'd0);
    chk("por_err", {29'd0, err}, 32'd0);
    chk("por_rdata", rdata[1], 32'd0);
    chk("por_fetch", fi[1], 32'd0);
    rst = 1'b1;

    txn(1, 2, 1'b0, 1'b1, 15'h000, 32'hA5A50000, 32'h0, 1'b0, "seed_w0");

    // Reset held two cycles with read_enable high, then released with it still high.
    @(negedge clk);
    rst = 1'b0;
    read_enable = 1'b1;
    addr_mem = 15'h000;
    repeat (2) @(negedge clk);
    chk("rst_ready", {29'd0, rdy}, 32'd0);
    chk("rst_rdata", rdata[1], 32'd0);
    chk("rst_fetch", fi[1], 32'd0);
    chk("rst_err", {29'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    await_ready(1, 2, "post_rst_read");
    chk("post_rst_read_rdata", rdata[1], 32'hA5A50000);
    repeat (5) @(negedge clk);

    // Table-driven transactions on the one-wait-state instance.
    for (int i = 0; i < 10; i++) begin
      txn(1, 2, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
          vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Fetch port: one-cycle latency, addresses wrap.
    addr = 15'h005;
    @(negedge clk);
    chk("fetch_5", fi[1], BC ? 32'hDEADBEEF : 32'h0BAD0BAD);
    addr = 15'h003;
    @(negedge clk);
    chk("fetch_3", fi[1], 32'h12345678);
    addr = 15'h405;
    @(negedge clk);
    chk("fetch_wrap", fi[1], BC ? 32'hDEADBEEF : 32'h0BAD0BAD);

    // Zero and three wait states.
    txn(0, 1, 1'b1, 1'b0, 15'h003, 32'h0, 32'h12345678, 1'b0, "ws0_read");
    txn(2, 4, 1'b1, 1'b0, 15'h003, 32'h0, 32'h12345678, 1'b0, "ws3_read");

    // Same-cycle fetch and write to one word: fetch sees the old word first.
    txn(1, 2, 1'b0, 1'b1, 15'h007, 32'h00001111, 32'h12345678, 1'b0, "seed_w7");
    addr = 15'h007;
    issue(1'b0, 1'b1, 15'h007, 32'h00002222);
    await_ready(1, 2, "rbw");
    chk("rbw_fetch_old", fi[1], 32'h00001111);
    @(negedge clk);
    chk("rbw_fetch_new", fi[1], 32'h00002222);
    repeat (4) @(negedge clk);

    // Reset during the second WAIT cycle aborts the write (three wait states).
    txn(2, 4, 1'b0, 1'b1, 15'h009, 32'h00000099, 32'h12345678, 1'b0, "seed_w9");
    issue(1'b0, 1'b1, 15'h009, 32'h00000077);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (8) begin
      if (rdy[2]) pulses++;
      @(negedge clk);
    end
    chk("midwait_no_ready", 32'(pulses), 32'd0);
    txn(2, 4, 1'b1, 1'b0, 15'h009, 32'h0, 32'h00000099, 1'b0, "midwait_readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's bus.
- Serves two ports from one unified word-addressed dual-port RAM:
  - Instruction fetch: addr in, fetch_instr out.
  - Data: read_enable/write_enable, addr_mem, data_out in; mem_rdata/mem_ready out.
- Data accesses pass through a wait-state FSM so the CPU sees a configurable, cycle-exact response latency.
- Sits between cpu and on-chip block RAM at top level.

Parameters:
- DEPTH_LOG2, 10, RAM holds 2**DEPTH_LOG2 32-bit words (1..15).
- WAIT_STATES, 1, extra cycles inserted before each data response (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- addr  in  15  instruction fetch word address.
- fetch_instr  out  32  instruction word for addr, registered.
- read_enable  in  1  data read request.
- write_enable  in  1  data write request.
- addr_mem  in  15  data word address.
- data_out  in  32  CPU write data.
- mem_rdata  out  32  data read result, valid while mem_ready=1.
- mem_ready  out  1  one-cycle data transaction completion pulse.
- mem_err  out  1  one-cycle error pulse, coincident with mem_ready.

Behaviour:
- Reset (rst=0 at a rising edge):
  - fetch_instr=0, mem_rdata=0, mem_ready=0, mem_err=0; FSM forced to IDLE.
  - Any in-flight transaction is aborted; a pending write is discarded.
  - RAM contents are not cleared.
- Fetch port:
  - Every cycle, fetch_instr <= RAM[addr mod DEPTH]. One-cycle latency, no handshake.
  - Fetch and data write to the same word in the same cycle: fetch returns the old word (read-before-write).
- Data FSM states IDLE, WAIT, RESP:
  - IDLE: samples read_enable/write_enable. If either is 1, latch addr_mem, data_out and op. Go to WAIT with counter=WAIT_STATES-1, or directly to RESP if WAIT_STATES=0.
  - WAIT: decrement counter; at 0, go to RESP. Request inputs are ignored; latched values are used.
  - RESP: perform access on latched values.
    - Write: RAM[a] <= wdata.
    - Read: mem_rdata <= RAM[a].
    - mem_ready=1 for exactly one cycle, then return to IDLE.
- Latency: request sampled at edge t0 -> mem_ready high in the cycle after edge t0+WAIT_STATES+1.
- Back-to-back requests: the CPU must drop its enable during the mem_ready cycle. An enable still high in the first IDLE cycle starts a new transaction.
- read_enable and write_enable both 1 when sampled:
  - No RAM access; mem_rdata=0.
  - mem_ready=1 and mem_err=1 in the response cycle.
- mem_rdata holds its last value between transactions and updates only in a read response.
- Write responses leave mem_rdata unchanged.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined: a data access with addr_mem >= 2**DEPTH_LOG2 completes with normal latency and sets mem_err=1.
  - Writes are dropped.
  - Reads return mem_rdata=0.
  - Fetch addresses are still wrapped.
- Undefined: data addresses wrap modulo 2**DEPTH_LOG2; mem_err only flags simultaneous read+write.

Decomposition:
- Package cpu_mem_pkg:
  - ADDR_W=15, DATA_W=32.
  - Data FSM state enum {IDLE, WAIT, RESP}.
  - Op encoding {OP_RD, OP_WR, OP_BAD}.
- Sub-module mem_dp_ram:
  - Synchronous dual-port RAM: port A read-only fetch, port B read/write data.
  - Read-before-write semantics; inferable as block RAM.
- cpu_mem_responder contains the FSM, wait counter, latches and error logic.

Test Plan:
- Reset: hold rst=0 two cycles with read_enable=1 -> all outputs 0, no mem_ready. After rst=1, first IDLE sample starts a transaction.
- Write/readback, WAIT_STATES=1:
  - Write 0xDEADBEEF to addr_mem=0x005 at edge t0 -> mem_ready high after edge t0+2.
  - Read 0x005 -> mem_rdata=0xDEADBEEF with mem_ready.
  - Fetch addr=0x005 -> fetch_instr=0xDEADBEEF one cycle later.
- WAIT_STATES=0 and 3: single read -> mem_ready exactly 1 and 4 cycles after the sampling edge; pulse width exactly 1.
- Same-cycle fetch vs write: RAM[7]=0x1111, write 0x2222 to 7 while addr=7 -> fetch_instr=0x1111, then 0x2222 the following cycle.
- read_enable=write_enable=1 at addr_mem=3 -> mem_ready=1, mem_err=1, mem_rdata=0; RAM[3] unchanged on readback.
- Reset mid-WAIT (WAIT_STATES=3):
  - Write issued, rst=0 asserted in second WAIT cycle -> no mem_ready pulse, RAM word unchanged.
  - With MEM_BOUNDS_CHECK_EN and DEPTH_LOG2=10: write to addr_mem=0x400 -> mem_err=1; RAM[0] unchanged.
